// File: rtl/alu_issue_ctrl_if.sv
// Bundles the command, ALU, result and direct-load signals of alu_issue_ctrl.
// slave = issue controller side, master = environment (ALU, producer, consumer).
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds its payload stable while valid is high and ready is low.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic [ADDR_W-1:0] cmd_rd;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_out;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [ADDR_W-1:0] res_rd;
    logic              res_err;

    logic [1:0]        dbg_state;

    modport slave (
        input  ld_en, ld_addr, ld_data,
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out,
        output res_valid, res_data, res_rd, res_err,
        input  res_ready,
        output dbg_state
    );

    modport master (
        output ld_en, ld_addr, ld_data,
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out,
        input  res_valid, res_data, res_rd, res_err,
        output res_ready,
        input  dbg_state
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Operand/issue stage in front of the combinational ALU: register file, command accept,
// result writeback and result handshake. Optional opcode check: define ALU_ISSUE_OPCHK_EN.
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] rf [DEPTH];
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [3:0]        alu_op_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic [ADDR_W-1:0] res_rd_q;
    logic              res_err_q;
    logic              op_bad;
    logic              wb_en;

`ifdef ALU_ISSUE_OPCHK_EN
    assign op_bad = (alu_op_q > 4'b1000);
`else
    assign op_bad = 1'b0;
`endif

    assign wb_en = (state == EXEC) && !op_bad;

    // Writeback has priority over a direct load to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_en && (rd_q == ADDR_W'(i))) begin
                    rf[i] <= bus.alu_out;
                end else if (bus.ld_en && (bus.ld_addr == ADDR_W'(i))) begin
                    rf[i] <= bus.ld_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        alu_a_q  <= rf[bus.cmd_rs1];
                        alu_b_q  <= rf[bus.cmd_rs2];
                        alu_op_q <= bus.cmd_op;
                        rd_q     <= bus.cmd_rd;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q  <= op_bad ? '0 : bus.alu_out;
                    res_err_q   <= op_bad;
                    res_rd_q    <= rd_q;
                    res_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_err   = res_err_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed commands, a behavioural ALU,
// a transaction-level model with an expected-result queue, and literal spot checks.
module tb_alu_issue_ctrl;
`ifdef ALU_ISSUE_OPCHK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    alu_issue_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Combinational ALU seen by the DUT; undefined opcodes give 0.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a ^ b;
            4'd4:    return ~a;
            4'd5:    return a << 1;
            4'd6:    return a >> 1;
            4'd7:    return a | b;
            4'd8:    return b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_out = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: register file plus outstanding-command bookkeeping.
    logic [7:0] m_rf [4];
    logic       m_busy, m_wb, m_res_valid, m_err;
    logic [7:0] m_a, m_b;
    logic [3:0] m_op;
    logic [1:0] m_rd, m_res_rd;
    logic [7:0] exp_q [$];

    logic       t_acc, t_hs, t_bad;
    logic [7:0] t_a, t_b;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_busy = 0; m_wb = 0; m_res_valid = 0; m_err = 0;
        m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_res_rd = 0;
        exp_q.delete();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                t_acc = !m_busy && bus.cmd_valid;
                t_hs  = m_res_valid && bus.res_ready;
                t_a   = m_rf[bus.cmd_rs1];
                t_b   = m_rf[bus.cmd_rs2];
                if (bus.ld_en) m_rf[bus.ld_addr] = bus.ld_data;
                if (m_wb) begin
                    t_bad = OPCHK && (m_op > 4'd8);
                    if (!t_bad) m_rf[m_rd] = alu_f(m_a, m_b, m_op);
                    m_err       = t_bad;
                    m_res_rd    = m_rd;
                    m_res_valid = 1;
                    m_wb        = 0;
                end else if (t_hs) begin
                    m_res_valid = 0;
                    m_err       = 0;
                    m_busy      = 0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (t_acc) begin
                    m_a = t_a; m_b = t_b; m_op = bus.cmd_op; m_rd = bus.cmd_rd;
                    m_busy = 1; m_wb = 1;
                    t_bad = OPCHK && (bus.cmd_op > 4'd8);
                    exp_q.push_back(t_bad ? 8'h00 : alu_f(t_a, t_b, bus.cmd_op));
                end
            end
        end
    end

    // Every-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                chk("cmd_ready", bus.cmd_ready, !m_busy);
                chk("res_valid", bus.res_valid, m_res_valid);
                chk("res_err",   bus.res_err,   m_err);
                chk("alu_a",     bus.alu_a,     m_a);
                chk("alu_b",     bus.alu_b,     m_b);
                chk("alu_op",    bus.alu_op,    m_op);
                if (m_res_valid) begin
                    if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
                    else chk("res_data", bus.res_data, exp_q[0]);
                    chk("res_rd", bus.res_rd, m_res_rd);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic ld(input logic [1:0] addr, input logic [7:0] data);
        bus.ld_en = 1; bus.ld_addr = addr; bus.ld_data = data;
        @(negedge clk);
        bus.ld_en = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [1:0] rd);
        bit rdy, got;
        got = 0;
        bus.cmd_valid = 1; bus.cmd_op = op;
        bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_rd = rd;
        for (int i = 0; i < 50; i++) begin
            rdy = bus.cmd_ready;
            @(negedge clk);
            if (rdy) begin
                got = 1;
                break;
            end
        end
        bus.cmd_valid = 0;
        if (!got) chk("issue_timeout", 0, 1);
    endtask

    task automatic wait_res();
        bit got;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.res_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("res_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 0;
        bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_rs1 = 0; bus.cmd_rs2 = 0; bus.cmd_rd = 0;
        bus.res_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_alu_a",     bus.alu_a,     8'h00);
        chk("rst_res_data",  bus.res_data,  8'h00);
        rst_n = 1;
        @(negedge clk);

        // Basic add and its latency.
        ld(0, 8'h0F); ld(1, 8'h01);
        issue(4'd0, 0, 1, 2);
        chk("t1_alu_a", bus.alu_a, 8'h0F);
        chk("t1_alu_b", bus.alu_b, 8'h01);
        chk("t1_res_valid_early", bus.res_valid, 0);
        @(negedge clk);
        chk("t1_res_valid", bus.res_valid, 1);
        chk("t1_res_data",  bus.res_data,  8'h10);
        chk("t1_res_rd",    bus.res_rd,    2);
        issue(4'd8, 0, 2, 3);
        chk("t1_rf2", bus.alu_b, 8'h10);
        wait_res();

        // Wrap-around.
        ld(0, 8'hFF);
        issue(4'd0, 0, 1, 3);
        @(negedge clk);
        chk("t2_wrap", bus.res_data, 8'h00);

        // Back-pressure: result held, queued command waits for the handshake.
        issue(4'd2, 0, 1, 0);
        bus.res_ready = 0;
        bus.cmd_valid = 1; bus.cmd_op = 4'd1; bus.cmd_rs1 = 0; bus.cmd_rs2 = 1; bus.cmd_rd = 1;
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_valid", bus.res_valid, 1);
            chk("t3_hold_data",  bus.res_data,  8'h01);
            chk("t3_hold_ready", bus.cmd_ready, 0);
        end
        bus.res_ready = 1;
        @(negedge clk);
        chk("t3_after_hs_valid", bus.res_valid, 0);
        chk("t3_not_yet_op",     bus.alu_op,    4'd2);
        @(negedge clk);
        chk("t3_accepted_op", bus.alu_op, 4'd1);
        chk("t3_accepted_a",  bus.alu_a,  8'h01);
        bus.cmd_valid = 0;
        wait_res();
        chk("t3_sub", bus.res_data, 8'h00);

        // Writeback vs. direct load collisions, rs1==rs2==rd.
        ld(0, 8'h0F); ld(1, 8'hF0);
        issue(4'd7, 0, 1, 2);
        bus.ld_en = 1; bus.ld_addr = 2; bus.ld_data = 8'hAA;
        @(negedge clk);
        bus.ld_en = 0;
        chk("t4_or", bus.res_data, 8'hFF);
        issue(4'd0, 2, 2, 2);
        chk("t4_same_a", bus.alu_a, 8'hFF);
        chk("t4_same_b", bus.alu_b, 8'hFF);
        wait_res();
        chk("t4_same_sum", bus.res_data, 8'hFE);
        issue(4'd0, 0, 1, 3);
        bus.ld_en = 1; bus.ld_addr = 1; bus.ld_data = 8'h33;
        @(negedge clk);
        bus.ld_en = 0;
        issue(4'd0, 1, 3, 0);
        chk("t4_ld_other", bus.alu_a, 8'h33);
        chk("t4_wb_other", bus.alu_b, 8'hFF);
        wait_res();
        chk("t4_sum2", bus.res_data, 8'h32);

        // Reset during EXEC.
        issue(4'd0, 0, 1, 3);
        #2 rst_n = 0;
        #1;
        chk("t5_rst_res_valid", bus.res_valid, 0);
        chk("t5_rst_cmd_ready", bus.cmd_ready, 1);
        chk("t5_rst_alu_a",     bus.alu_a,     8'h00);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        issue(4'd0, 0, 1, 0);
        chk("t5_rf0", bus.alu_a, 8'h00);
        chk("t5_rf1", bus.alu_b, 8'h00);
        wait_res();
        issue(4'd0, 2, 3, 1);
        chk("t5_rf2", bus.alu_a, 8'h00);
        chk("t5_rf3", bus.alu_b, 8'h00);
        wait_res();

        // Out-of-range opcode.
        @(negedge clk);
        ld(1, 8'h55);
        issue(4'd12, 1, 0, 1);
        @(negedge clk);
        chk("t6_err",  bus.res_err,  OPCHK ? 1 : 0);
        chk("t6_data", bus.res_data, 8'h00);
        issue(4'd8, 0, 1, 0);
        chk("t6_rf1", bus.alu_b, OPCHK ? 8'h55 : 8'h00);
        wait_res();
        repeat (3) @(negedge clk);

        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Operand/issue stage directly upstream of the 8-bit combinational ALU.
- Holds a small operand register file and accepts register-addressed commands over a valid/ready handshake.
- Drives registered A/B/op into the ALU, captures its output one cycle later, writes it back to the register file and presents it on a result handshake.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU data width.
- ADDR_W, 2, register address width; register file depth = 2**ADDR_W (default 4 entries).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ld_en  in  1  direct register-file write strobe.
- ld_addr  in  ADDR_W  direct write address.
- ld_data  in  DATA_W  direct write data.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  4  ALU opcode, passed through unchanged.
- cmd_rs1  in  ADDR_W  source register for A.
- cmd_rs2  in  ADDR_W  source register for B.
- cmd_rd  in  ADDR_W  destination register.
- alu_a  out  DATA_W  registered operand A to the ALU.
- alu_b  out  DATA_W  registered operand B to the ALU.
- alu_op  out  4  registered opcode to the ALU.
- alu_out  in  DATA_W  combinational ALU result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_W  captured result.
- res_rd  out  ADDR_W  destination of the result.
- res_err  out  1  opcode rejected; only meaningful with the optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All register-file entries, alu_a, alu_b, alu_op, res_data, res_rd = 0.
  - res_valid = 0, res_err = 0, cmd_ready = 1.
  - Reset mid-operation discards the in-flight command and the pending result.
- FSM states: IDLE, EXEC, RESP.
  - IDLE:
    - cmd_ready = 1.
    - On cmd_valid & cmd_ready: alu_a <= rf[rs1], alu_b <= rf[rs2], alu_op <= cmd_op, latch rd; go to EXEC.
    - Operands are read from pre-edge register contents, with no bypass of a same-cycle ld_en write.
  - EXEC:
    - cmd_ready = 0.
    - res_data <= alu_out, res_rd <= rd, rf[rd] <= alu_out, res_valid <= 1; go to RESP.
  - RESP:
    - cmd_ready = 0; res_valid = 1.
    - res_data and res_rd are held stable until res_ready.
    - On res_ready: res_valid <= 0; go to IDLE.
    - A new command is accepted no earlier than the cycle after the handshake, so there is no pipelining.
- Latency:
  - Command accepted at edge N → alu_* valid after N → writeback and res_valid=1 after edge N+1.
  - Minimum command-to-command spacing is 3 cycles with res_ready held high.
- alu_a, alu_b and alu_op hold their values outside EXEC; they change only on command accept.
- Arithmetic width: writeback is exactly DATA_W bits of alu_out. Wrap-around is the ALU's behaviour; this block does not add or drop bits.
- rs1 == rs2 is legal: both operands carry the same value.
- rd equal to rs1 or rs2 is legal: the source is read before writeback.
- ld_en and EXEC writeback to the same address in the same cycle: writeback wins and the ld write is dropped.
- ld_en to a different address in the same cycle: both writes take effect.
- ld_en is accepted in every state.
- cmd_valid while cmd_ready=0: ignored. The command is not consumed, and the upstream holds it stable.

Optional Feature:
- Macro: ALU_ISSUE_OPCHK_EN.
- Defined:
  - In EXEC, if alu_op > 4'b1000, there is no rf writeback.
  - res_err <= 1 with res_data <= 0; the RESP handshake is otherwise unchanged.
  - res_err clears when the result is accepted.
- Undefined:
  - res_err is tied to 0.
  - Every opcode is written back as produced by the ALU; undefined opcodes write 0.

Test Plan:
- Load rf[0]=8'h0F, rf[1]=8'h01; cmd op=0000 rs1=0 rs2=1 rd=2 → alu_a=0F, alu_b=01 one cycle after accept; res_valid next cycle with res_data=8'h10, res_rd=2; rf[2]=10.
- rf[0]=8'hFF, rf[1]=8'h01, op=0000 rd=3 → res_data=8'h00 (wrap); rf[3]=00.
- Hold res_ready=0 for 5 cycles → res_valid stays 1 and res_data is stable; cmd_ready=0 throughout; cmd_valid held is not accepted until the cycle after res_ready=1.
- ld_en addr=2 data=8'hAA during EXEC with rd=2, op=0111 on A=8'h0F, B=8'hF0 → rf[2]=8'hFF (writeback wins).
- Assert rst_n=0 during EXEC → res_valid=0, cmd_ready=1, rf all 0 immediately; no writeback occurs.
- With ALU_ISSUE_OPCHK_EN, op=1100 rd=1 with rf[1]=8'h55 → res_err=1, res_data=0, rf[1] stays 55. Without the macro → rf[1]=00, res_err=0.
